// File: rtl/audio_stream_engine.sv
// Record/playback engine between the codec frame interface and the RAM command port.
// One frame FIFO is shared: RECORD buffers ADC frames ahead of memory writes,
// PLAY prefetches memory words ahead of DAC frame requests.
module audio_stream_engine #(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned MAX_FRAMES = 2**24-1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_record,
  input  logic                           cmd_play,
  input  logic                           cmd_stop,
  input  logic                           play_loop,
  input  logic                           adc_valid,
  input  logic [SAMPLE_W*CHANNELS-1:0]   adc_data,
  input  logic                           dac_req,
  output logic [SAMPLE_W*CHANNELS-1:0]   dac_data,
  output logic                           dac_valid,
  output logic                           mem_cmd_valid,
  input  logic                           mem_cmd_ready,
  output logic                           mem_cmd_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [SAMPLE_W*CHANNELS-1:0]   mem_wdata,
  input  logic [SAMPLE_W*CHANNELS-1:0]   mem_rdata,
  input  logic                           mem_rvalid,
  output logic [2:0]                     state,
  output logic [ADDR_W-1:0]              rec_length,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int unsigned FW = SAMPLE_W * CHANNELS;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REC        = 3'd1,
    S_REC_DRAIN  = 3'd2,
    S_PLAY       = 3'd3,
    S_PLAY_FLUSH = 3'd4
  } state_t;

  state_t            state_q;
  logic [FW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q, wptr_d, rptr_d;
  logic [CW-1:0]     count_q, count_d, outst_q, outst_d;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q, rec_len_q;
  logic              ovf_q, udf_q, dac_valid_q;
  logic [FW-1:0]     dac_data_q;

  logic          fifo_full, fifo_empty, wr_cmd, rd_cmd, wr_pop, rd_acc, rsp_ok;
  logic          rec_push, play_push, dac_pop, push, pop;
  logic [CW:0]   inflight;
  logic [FW-1:0] head, push_data;

  // Command/FIFO decode; memory command is derived from registered state so it
  // stays stable while waiting for ready.
  always_comb begin
    head       = fifo_mem[rptr_q];
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    inflight   = {1'b0, count_q} + {1'b0, outst_q};
    wr_cmd     = ((state_q == S_REC) || (state_q == S_REC_DRAIN)) && !fifo_empty;
    rd_cmd     = (state_q == S_PLAY) && (inflight < (CW+1)'(FIFO_DEPTH)) &&
                 (rd_addr_q < rec_len_q);
    wr_pop     = wr_cmd && mem_cmd_ready;
    rd_acc     = rd_cmd && mem_cmd_ready;
    rsp_ok     = mem_rvalid && (outst_q != '0);
    rec_push   = (state_q == S_REC) && adc_valid && !fifo_full;
    play_push  = (state_q == S_PLAY) && rsp_ok;
    dac_pop    = (state_q == S_PLAY) && dac_req && !fifo_empty;
    push       = rec_push || play_push;
    pop        = wr_pop || dac_pop;
    push_data  = (state_q == S_PLAY) ? mem_rdata : adc_data;
    wptr_d     = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + PW'(1) : rptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    outst_d    = outst_q + CW'(rd_acc) - CW'(rsp_ok);
  end

  // Frame storage; contents need no reset because readers are gated by count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= push_data;
  end

  // Control FSM with FIFO pointers, address counters and registered status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      outst_q     <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      rec_len_q   <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      dac_valid_q <= 1'b0;
      dac_data_q  <= '0;
    end else begin
      dac_valid_q <= dac_req;
      if (dac_req) begin
        dac_data_q <= dac_pop ? head : '0;
        if ((state_q == S_PLAY) && fifo_empty) udf_q <= 1'b1;
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if ((state_q == S_PLAY) || (state_q == S_PLAY_FLUSH)) outst_q <= outst_d;
      case (state_q)
        S_IDLE: begin
          if (!cmd_stop && (cmd_record || cmd_play)) begin
            state_q   <= cmd_record ? S_REC : S_PLAY;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
          end
        end
        S_REC: begin
          if (adc_valid && fifo_full) ovf_q <= 1'b1;
          if (wr_pop) wr_addr_q <= wr_addr_q + ADDR_W'(1);
          if (cmd_stop || (wr_pop && (wr_addr_q + ADDR_W'(1) == MAX_A)))
            state_q <= S_REC_DRAIN;
        end
        S_REC_DRAIN: begin
          if (wr_pop) wr_addr_q <= wr_addr_q + ADDR_W'(1);
          if (fifo_empty) begin
            rec_len_q <= wr_addr_q;
            state_q   <= S_IDLE;
          end
        end
        S_PLAY: begin
          if (rd_acc) rd_addr_q <= rd_addr_q + ADDR_W'(1);
          // A read accepted in the stop cycle still counts as outstanding so its
          // data is waited for and discarded in the flush state.
          if (cmd_stop) begin
            state_q <= S_PLAY_FLUSH;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
          end else if (rec_len_q == '0) begin
            state_q <= S_IDLE;
          end else if (rd_addr_q == rec_len_q) begin
            if (play_loop) rd_addr_q <= '0;
            else if (fifo_empty && (outst_q == '0)) state_q <= S_IDLE;
          end
        end
        S_PLAY_FLUSH: begin
          if (outst_q == '0) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_cmd_valid = wr_cmd || rd_cmd;
  assign mem_cmd_we    = wr_cmd;
  assign mem_addr      = wr_cmd ? wr_addr_q : (rd_cmd ? rd_addr_q : '0);
  assign mem_wdata     = wr_cmd ? head : '0;
  assign dac_data      = dac_data_q;
  assign dac_valid     = dac_valid_q;
  assign state         = state_q;
  assign rec_length    = rec_len_q;
  assign overflow      = ovf_q;
  assign underflow     = udf_q;

endmodule

// File: tb/tb_audio_stream_engine.sv
// Scoreboard bench for audio_stream_engine: expected memory writes and DAC frames are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_audio_stream_engine;

  localparam int unsigned FW = 32;
  localparam int unsigned AW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_record, cmd_play, cmd_stop, play_loop;
  logic          adc_valid, dac_req, dac_valid;
  logic [FW-1:0] adc_data, dac_data, mem_wdata, mem_rdata;
  logic          mem_cmd_valid, mem_cmd_ready, mem_cmd_we, mem_rvalid;
  logic [AW-1:0] mem_addr, rec_length;
  logic [2:0]    state;
  logic          overflow, underflow;

  audio_stream_engine #(
    .SAMPLE_W(16), .CHANNELS(2), .FIFO_DEPTH(16), .ADDR_W(24), .MAX_FRAMES(2**24-1)
  ) dut (
    .clk(clk), .reset(reset), .cmd_record(cmd_record), .cmd_play(cmd_play),
    .cmd_stop(cmd_stop), .play_loop(play_loop), .adc_valid(adc_valid),
    .adc_data(adc_data), .dac_req(dac_req), .dac_data(dac_data), .dac_valid(dac_valid),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .state(state), .rec_length(rec_length),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [FW-1:0] data;
  } wr_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic [FW-1:0] mem_model [64];
  wr_t           wq[$];
  logic [FW-1:0] dq[$];
  logic [AW-1:0] rd_log[$];
  int            rsp_due[$];
  logic [FW-1:0] rsp_data[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] frame(input int i);
    return {16'(2*i+1), 16'(2*i+2)};
  endfunction

  // One clock: log the transfer about to be accepted, advance, sample outputs,
  // clear strobes and drive any memory response due at the next edge.
  task automatic tick();
    wr_t e;
    if (mem_cmd_valid && mem_cmd_ready) begin
      if (mem_cmd_we) begin
        mem_model[mem_addr[5:0]] = mem_wdata;
        if (wq.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          e = wq.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
        end
      end else begin
        rd_log.push_back(mem_addr);
        rsp_due.push_back(cyc + 4);
        rsp_data.push_back(mem_model[mem_addr[5:0]]);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (dac_valid) begin
      if (dq.size() == 0) check("dac_unexpected", 1, 0);
      else check("dac_data", dac_data, dq.pop_front());
    end
    cmd_record = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0;
    adc_valid  = 1'b0; dac_req  = 1'b0;
    if (rsp_due.size() > 0 && rsp_due[0] == cyc + 1) begin
      void'(rsp_due.pop_front());
      mem_rvalid = 1'b1;
      mem_rdata  = rsp_data.pop_front();
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (state !== 3'd0 && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, state, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_mem"}, {mem_cmd_valid, mem_cmd_we, mem_addr, mem_wdata}, 0);
    check({tag, "_dac"}, {dac_valid, dac_data}, 0);
    check({tag, "_stat"}, {rec_length, overflow, underflow}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nlog;
    logic [AW-1:0] exp_rd [7];
    reset = 1'b1; cmd_record = 1'b0; cmd_play = 1'b0; cmd_stop = 1'b0; play_loop = 1'b0;
    adc_valid = 1'b0; adc_data = '0; dac_req = 1'b0; mem_cmd_ready = 1'b0;
    mem_rdata = '0; mem_rvalid = 1'b0;
    for (int i = 0; i < 64; i++) mem_model[i] = '0;
    #1 check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Record and play together -> record wins; play during record is ignored.
    cmd_record = 1'b1; cmd_play = 1'b1; tick();
    check("rec_priority", state, 1);
    cmd_play = 1'b1; tick();
    check("play_in_rec", state, 1);
    cmd_stop = 1'b1; tick();
    check("empty_drain", state, 2);
    tick();
    check("empty_done", {state, rec_length}, 0);
    // Playback of an empty recording returns to idle on the next cycle.
    cmd_play = 1'b1; tick();
    check("play_zero_len", state, 3);
    tick();
    check("play_zero_idle", state, 0);

    // Asynchronous reset in the middle of a pending write.
    cmd_record = 1'b1; tick();
    adc_valid = 1'b1; adc_data = 32'hDEAD_BEEF; tick();
    check("first_valid", {mem_cmd_valid, mem_cmd_we}, 2'b11);
    #2 reset = 1'b1;
    #1 check_all_zero("midrec_reset");
    @(negedge clk);
    reset = 1'b0;

    // Stalled memory: 17 frames into a 16-deep FIFO, one dropped.
    cmd_record = 1'b1; tick();
    for (int i = 0; i < 17; i++) begin
      adc_valid = 1'b1; adc_data = 32'h100 + 32'(i);
      if (i < 16) wq.push_back('{addr: AW'(i), data: 32'h100 + 32'(i)});
      tick();
    end
    check("ovf_set", overflow, 1);
    check("stall_hold", {mem_cmd_valid, mem_addr, mem_wdata}, {1'b1, 24'd0, 32'h100});
    mem_cmd_ready = 1'b1; cmd_stop = 1'b1; tick();
    check("ovf_drain_state", state, 2);
    wait_idle("ovf_idle", 40);
    check("ovf_writes_done", wq.size(), 0);
    check("ovf_rec_len", {rec_length, overflow}, {24'd16, 1'b1});

    // Record five frames with memory always ready.
    cmd_record = 1'b1; tick();
    check("rec_clears_ovf", overflow, 0);
    for (int i = 0; i < 5; i++) begin
      adc_valid = 1'b1; adc_data = frame(i);
      wq.push_back('{addr: AW'(i), data: frame(i)});
      tick(); tick();
    end
    cmd_stop = 1'b1; tick();
    check("rec5_drain", state, 2);
    tick();
    check("rec5_idle", {state, rec_length}, {3'd0, 24'd5});
    check("rec5_writes", wq.size(), 0);

    // Play the five frames back, then one request too many.
    rd_log.delete();
    cmd_play = 1'b1; tick();
    ticks(12);
    check("play_nreads", rd_log.size(), 5);
    for (int i = 0; i < 5 && i < rd_log.size(); i++) check("play_rd_addr", rd_log[i], i);
    check("play_state", state, 3);
    for (int i = 0; i < 5; i++) begin
      dac_req = 1'b1; dq.push_back(frame(i)); tick(); ticks(3);
    end
    check("play_end_idle", state, 0);
    dac_req = 1'b1; dq.push_back('0); tick();
    check("idle_req_no_udf", underflow, 0);
    check("play_dac_done", dq.size(), 0);

    // Request before any data arrives -> underflow; then stop with nothing in flight.
    cmd_play = 1'b1; tick();
    dac_req = 1'b1; dq.push_back('0); tick();
    check("udf_set", underflow, 1);
    ticks(10);
    cmd_stop = 1'b1; tick();
    check("flush_state", state, 4);
    tick();
    check("flush_idle", {state, underflow}, {3'd0, 1'b1});

    // Three-frame recording for looped playback.
    cmd_record = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      adc_valid = 1'b1; adc_data = 32'hA0 + 32'(i);
      wq.push_back('{addr: AW'(i), data: 32'hA0 + 32'(i)});
      tick();
    end
    cmd_stop = 1'b1; tick();
    wait_idle("rec3_idle", 20);
    check("rec3_len", rec_length, 3);

    rd_log.delete();
    play_loop = 1'b1; cmd_play = 1'b1; tick();
    for (int n = 0; n < 40 && rd_log.size() < 7; n++) tick();
    mem_cmd_ready = 1'b0;
    exp_rd = '{0, 1, 2, 0, 1, 2, 0};
    check("loop_nreads", rd_log.size() >= 7, 1);
    for (int i = 0; i < 7 && i < rd_log.size(); i++) check("loop_rd_addr", rd_log[i], exp_rd[i]);
    ticks(5);
    nlog = rd_log.size();
    mem_cmd_ready = 1'b1; ticks(2);
    check("loop_two_more", rd_log.size(), nlog + 2);
    mem_cmd_ready = 1'b0; cmd_stop = 1'b1; tick();
    check("loop_flush", state, 4);
    nlog = rd_log.size();
    mem_cmd_ready = 1'b1; tick();
    check("flush_wait1", state, 4);
    tick();
    check("flush_wait2", state, 4);
    tick();
    check("flush_done", state, 0);
    check("flush_no_reads", rd_log.size(), nlog);
    check("flush_rsp_done", rsp_due.size(), 0);

    // Playback after the flush must start from a clean FIFO.
    play_loop = 1'b0; cmd_play = 1'b1; tick();
    ticks(10);
    for (int i = 0; i < 3; i++) begin
      dac_req = 1'b1; dq.push_back(32'hA0 + 32'(i)); tick(); ticks(3);
    end
    check("replay_idle", state, 0);
    check("replay_dac_done", dq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
